// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   mem_size_t      : request access size encoding (byte/half/word/illegal)
//   mem_rsp_state_t : responder FSM states
//   is_misaligned() : true when an access size does not fit its byte offset
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } mem_rsp_state_t;

    // Halves must sit on an even byte, words on a multiple of four.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
        case (size)
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return addr_lo != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational little-endian lane steering for one 32-bit word.
//   addr_lo_i : byte offset within the word
//   size_i    : access size
//   zext_i    : loads only, 1 = zero-extend, 0 = sign-extend
//   wdata_i   : right-justified store data
//   rword_i   : current contents of the addressed word
//   be_o      : store byte enables, bit n = byte lane n
//   wdata_o   : store data replicated into every candidate lane
//   rdata_o   : selected load lane(s), extended to 32 bits
module load_store_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  mem_size_t   size_i,
    input  logic        zext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign lane_byte = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign lane_half = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
        case (size_i)
            SIZE_BYTE: begin
                // Replicating the byte lets the enables alone pick the lane.
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = zext_i ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            end
            SIZE_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = zext_i ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
            end
            SIZE_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rword_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_memory_responder.sv
// Responder side of the CPU data-memory load/store interface.
// Accepts one request at a time, waits WAIT_STATES cycles, then presents a
// response that is held until the initiator takes it.
//   i_Clock / i_Reset        : clock, synchronous active-low reset
//   i_ReqValid / o_ReqReady  : request handshake (ready only in IDLE)
//   i_ReqWrite, i_ReqAddress, i_ReqSize, i_ReqUnsigned, i_ReqWriteData : request
//   o_RspValid / i_RspReady  : response handshake
//   o_RspReadData, o_RspError : formatted load data (0 for stores/errors), error flag
module data_memory_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_ReqValid,
    output logic                  o_ReqReady,
    input  logic                  i_ReqWrite,
    input  logic [ADDR_WIDTH-1:0] i_ReqAddress,
    input  logic [1:0]            i_ReqSize,
    input  logic                  i_ReqUnsigned,
    input  logic [31:0]           i_ReqWriteData,
    output logic                  o_RspValid,
    input  logic                  i_RspReady,
    output logic [31:0]           o_RspReadData,
    output logic                  o_RspError
);

    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    mem_rsp_state_t        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    mem_size_t             size_q, size_d;
    logic                  zext_q, zext_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [31:0]           mem_q [DEPTH_WORDS];

    // The request being worked on: live inputs while IDLE (so a zero-wait
    // access can complete on its accept edge), the latched copy afterwards.
    logic                  cur_write;
    logic [ADDR_WIDTH-1:0] cur_addr;
    mem_size_t             cur_size;
    logic                  cur_zext;
    logic [31:0]           cur_wdata;
    logic [ADDR_WIDTH-3:0] cur_word;
    logic [IDX_W-1:0]      mem_idx;
    logic                  cur_err;
    logic                  enter_rsp;
    logic                  mem_we;
    logic [31:0]           mem_word;
    logic [3:0]            store_be;
    logic [31:0]           store_data;
    logic [31:0]           load_data;

    always_comb begin
        if (state_q == IDLE) begin
            cur_write = i_ReqWrite;
            cur_addr  = i_ReqAddress;
            cur_size  = mem_size_t'(i_ReqSize);
            cur_zext  = i_ReqUnsigned;
            cur_wdata = i_ReqWriteData;
        end else begin
            cur_write = write_q;
            cur_addr  = addr_q;
            cur_size  = size_q;
            cur_zext  = zext_q;
            cur_wdata = wdata_q;
        end
    end

    assign cur_word = cur_addr[ADDR_WIDTH-1:2];
    assign mem_idx  = cur_word[IDX_W-1:0];
    assign cur_err  = (cur_size == SIZE_ILLEGAL)
                   || is_misaligned(cur_size, cur_addr[1:0])
                   || (cur_word >= (ADDR_WIDTH-2)'(DEPTH_WORDS));
    assign mem_word = mem_q[mem_idx];

    load_store_align u_align (
        .addr_lo_i (cur_addr[1:0]),
        .size_i    (cur_size),
        .zext_i    (cur_zext),
        .wdata_i   (cur_wdata),
        .rword_i   (mem_word),
        .be_o      (store_be),
        .wdata_o   (store_data),
        .rdata_o   (load_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        size_d     = size_q;
        zext_d     = zext_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (i_ReqValid) begin
                    write_d = i_ReqWrite;
                    addr_d  = i_ReqAddress;
                    size_d  = mem_size_t'(i_ReqSize);
                    zext_d  = i_ReqUnsigned;
                    wdata_d = i_ReqWriteData;
                    cnt_d   = '0;
                    // Illegal requests never wait: they answer in the next cycle.
                    state_d = (WAIT_STATES > 0 && !cur_err) ? ACCESS : RESPOND;
                end
            end
            ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESPOND: begin
                if (i_RspReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The access itself happens once, on the edge that enters RESPOND;
        // the response registers then hold still until the handshake.
        enter_rsp = (state_d == RESPOND) && (state_q != RESPOND);
        if (enter_rsp) begin
            rsp_err_d  = cur_err;
            rsp_data_d = (!cur_err && !cur_write) ? load_data : 32'h0;
        end
        mem_we = i_Reset && enter_rsp && cur_write && !cur_err;
    end

    // NOTE: registers update with non-blocking assignments so every flop
    // samples its pre-edge value, independent of statement order.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rsp_data_q <= 32'h0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Request copy is only meaningful once a request is accepted.
    always_ff @(posedge i_Clock) begin
        write_q <= write_d;
        addr_q  <= addr_d;
        size_q  <= size_d;
        zext_q  <= zext_d;
        wdata_q <= wdata_d;
    end

    // NOTE: the backing array has no reset; clearing it would prevent RAM
    // inference and contents are undefined until written anyway.
    always_ff @(posedge i_Clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (store_be[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= store_data[8*b +: 8];
                end
            end
        end
    end

    assign o_ReqReady    = i_Reset && (state_q == IDLE);
    assign o_RspValid    = i_Reset && (state_q == RESPOND);
    assign o_RspReadData = i_Reset ? rsp_data_q : 32'h0;
    assign o_RspError    = i_Reset && rsp_err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed scenarios followed
// by randomized traffic compared against a byte-addressed reference model.
module tb_data_memory_responder;

    localparam int DEPTH = 1024;
    localparam int WAITS = 1;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [1:0]    req_size = 2'b00;
    logic          req_uns = 1'b0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    always #5 clk = ~clk;

    data_memory_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (WAITS),
        .ADDR_WIDTH  (AW)
    ) dut (
        .i_Clock        (clk),
        .i_Reset        (rst_n),
        .i_ReqValid     (req_valid),
        .o_ReqReady     (req_ready),
        .i_ReqWrite     (req_write),
        .i_ReqAddress   (req_addr),
        .i_ReqSize      (req_size),
        .i_ReqUnsigned  (req_uns),
        .i_ReqWriteData (req_wdata),
        .o_RspValid     (rsp_valid),
        .i_RspReady     (rsp_ready),
        .o_RspReadData  (rsp_rdata),
        .o_RspError     (rsp_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference memory, one entry per byte address.
    logic [7:0] mdl [int unsigned];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected response of one request, updating the model for stores.
    function automatic void model(input bit w, input logic [31:0] a, input logic [1:0] s,
                                  input bit u, input logic [31:0] d,
                                  output logic [31:0] rd, output logic err);
        int n;
        logic [31:0] v;
        err = (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0)
           || (a / 4 >= DEPTH);
        rd = 32'h0;
        if (err) return;
        n = 1 << s;
        if (w) begin
            for (int i = 0; i < n; i++) mdl[a + i] = 8'(d >> (8 * i));
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(mdl[a + i]) << (8 * i));
            if (n < 4 && !u && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 1);
            rd = v;
        end
    endfunction

    // One complete request/response exchange, checked against the model.
    task automatic req(input string tag, input bit w, input logic [31:0] a, input logic [1:0] s,
                       input bit u, input logic [31:0] d,
                       output logic [31:0] rd, output logic re);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          cyc;
        int          lat;
        rd = 32'h0;
        re = 1'b0;
        model(w, a, s, u, d, exp_rd, exp_err);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_size  = s;
        req_uns   = u;
        req_wdata = d;
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        if (req_ready !== 1'b1) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // Scramble the fields: the responder must use its latched copy.
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_size  = 2'($urandom);
        req_uns   = 1'($urandom);
        req_wdata = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (rsp_valid !== 1'b1 && lat < 20);
        check({tag, ".latency"}, 32'(lat), exp_err ? 32'd1 : 32'(WAITS + 1));
        check({tag, ".data"}, rsp_rdata, exp_rd);
        check({tag, ".error"}, 32'(rsp_err), 32'(exp_err));
        rd = rsp_rdata;
        re = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        re;
        logic [31:0] held;
        int          cyc;
        bit          w;
        bit          u;
        logic [1:0]  s;
        logic [31:0] a;

        // Reset holds everything quiet even with a request pending.
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h10;
        req_size  = 2'd2;
        repeat (2) begin
            @(negedge clk);
            check("rst.req_ready", 32'(req_ready), 32'd0);
            check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst.rsp_data", rsp_rdata, 32'h0);
            check("rst.rsp_err", 32'(rsp_err), 32'd0);
        end
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check("post_rst.req_ready", 32'(req_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("post_rst.no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Word store then load.
        req("sw_10", 1, 32'h10, 2'd2, 0, 32'hDEADBEEF, rd, re);
        req("sw_ffc", 1, 32'hFFC, 2'd2, 0, 32'h0BADF00D, rd, re);
        req("lw_10", 0, 32'h10, 2'd2, 0, 32'h0, rd, re);
        check("lw_10.const", rd, 32'hDEADBEEF);

        // Sub-word loads with both extensions.
        req("lb_13", 0, 32'h13, 2'd0, 0, 32'h0, rd, re);
        check("lb_13.const", rd, 32'hFFFFFFDE);
        req("lbu_13", 0, 32'h13, 2'd0, 1, 32'h0, rd, re);
        check("lbu_13.const", rd, 32'h000000DE);
        req("lh_12", 0, 32'h12, 2'd1, 0, 32'h0, rd, re);
        check("lh_12.const", rd, 32'hFFFFDEAD);
        req("lhu_10", 0, 32'h10, 2'd1, 1, 32'h0, rd, re);
        check("lhu_10.const", rd, 32'h0000BEEF);

        // Sub-word stores land in the right lanes only.
        req("sb_11", 1, 32'h11, 2'd0, 0, 32'h12345655, rd, re);
        req("lw_10b", 0, 32'h10, 2'd2, 0, 32'h0, rd, re);
        check("lw_10b.const", rd, 32'hDEAD55EF);
        req("sh_12", 1, 32'h12, 2'd1, 0, 32'h0000CAFE, rd, re);
        req("lw_10c", 0, 32'h10, 2'd2, 0, 32'h0, rd, re);
        check("lw_10c.const", rd, 32'hCAFE55EF);

        // Illegal requests: fast error response, no side effects.
        req("err_lw_12", 0, 32'h12, 2'd2, 0, 32'h0, rd, re);
        check("err_lw_12.flag", 32'(re), 32'd1);
        req("err_sh_13", 1, 32'h13, 2'd1, 0, 32'hFFFFFFFF, rd, re);
        check("err_sh_13.flag", 32'(re), 32'd1);
        req("err_size", 1, 32'h10, 2'd3, 0, 32'h11111111, rd, re);
        check("err_size.flag", 32'(re), 32'd1);
        req("err_range", 1, 32'h1000, 2'd2, 0, 32'h22222222, rd, re);
        check("err_range.flag", 32'(re), 32'd1);
        req("lw_ffc", 0, 32'hFFC, 2'd2, 0, 32'h0, rd, re);
        check("lw_ffc.const", rd, 32'h0BADF00D);
        req("lw_10d", 0, 32'h10, 2'd2, 0, 32'h0, rd, re);
        check("lw_10d.const", rd, 32'hCAFE55EF);

        // Response stall: outputs hold, new requests are ignored.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        req_size  = 2'd2;
        check("stall.ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (rsp_valid !== 1'b1 && cyc < 20);
        check("stall.rsp_valid", 32'(rsp_valid), 32'd1);
        held = rsp_rdata;
        check("stall.first_data", held, 32'hCAFE55EF);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_wdata = 32'h0;
        repeat (5) begin
            @(negedge clk);
            check("stall.valid_hold", 32'(rsp_valid), 32'd1);
            check("stall.data_hold", rsp_rdata, held);
            check("stall.err_hold", 32'(rsp_err), 32'd0);
            check("stall.req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req("lw_10e", 0, 32'h10, 2'd2, 0, 32'h0, rd, re);
        check("lw_10e.const", rd, 32'hCAFE55EF);

        // Reset during the wait of a store drops it.
        req("sw_20", 1, 32'h20, 2'd2, 0, 32'h11112222, rd, re);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_size  = 2'd2;
        req_wdata = 32'h33334444;
        check("midrst.ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req("lw_20", 0, 32'h20, 2'd2, 0, 32'h0, rd, re);
        check("lw_20.const", rd, 32'h11112222);

        // Randomized traffic over a small pre-initialized window.
        for (int i = 0; i < 16; i++) begin
            req("rnd_init", 1, 32'h40 + 32'(4 * i), 2'd2, 0, $urandom, rd, re);
        end
        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom);
            u = 1'($urandom);
            s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = 32'h40 + $urandom_range(0, 63);
            if ($urandom_range(0, 9) == 0) a = 32'h1000 + $urandom_range(0, 255);
            req("rnd", w, a, s, u, $urandom, rd, re);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
Responder end of the CPU data-memory load/store interface; the load/store unit is the initiator.
- Accepts one request at a time over a valid/ready handshake.
- Applies a configurable number of wait states, then returns a response over a second valid/ready handshake.
- Handles byte/half/word sizing, little-endian lane steering, sign/zero extension, and misalignment/range errors.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the backing array
WAIT_STATES, 1, extra cycles between request accept and response (0 allowed)
ADDR_WIDTH, 32, request address width

Ports:
i_Clock  in  1  system clock; all logic on rising edge
i_Reset  in  1  synchronous, active-low reset
i_ReqValid  in  1  request present
o_ReqReady  out  1  responder can accept a request
i_ReqWrite  in  1  1 = store, 0 = load
i_ReqAddress  in  ADDR_WIDTH  byte address
i_ReqSize  in  2  00 byte, 01 half, 10 word, 11 illegal
i_ReqUnsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
i_ReqWriteData  in  32  store data, right-justified
o_RspValid  out  1  response present
i_RspReady  in  1  initiator accepts response
o_RspReadData  out  32  formatted load data; 0 for stores and errors
o_RspError  out  1  request was illegal; no side effects

Behaviour:
- Reset
  - i_Reset=0 at a rising edge: state to IDLE, wait counter to 0.
  - While i_Reset=0: o_ReqReady=0, o_RspValid=0, o_RspReadData=0, o_RspError=0.
  - Array contents are not reset.
- State machine: IDLE, ACCESS, RESPOND.
- IDLE
  - o_ReqReady=1; it is 1 only in IDLE.
  - Accept on i_ReqValid & o_ReqReady at edge T: latch write, address, size, unsigned flag and write data.
  - Go to ACCESS if WAIT_STATES>0 and the request is legal; otherwise go to RESPOND.
- ACCESS
  - Counter counts WAIT_STATES cycles, width $clog2(WAIT_STATES+1).
  - Go to RESPOND at the edge ending the last wait cycle.
- Response timing for a legal request: o_RspValid rises in cycle T+1+WAIT_STATES.
- Side effects at the edge entering RESPOND:
  - Store: commits with byte enables.
  - Load: registers the formatted data into o_RspReadData.
- RESPOND
  - o_RspValid=1; o_RspReadData and o_RspError held stable until handshake.
  - On i_RspReady=1, return to IDLE next cycle.
  - Back-to-back throughput: one request per WAIT_STATES+2 cycles minimum.
- Error detection (at accept)
  - size=11.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - word index addr[ADDR_WIDTH-1:2] >= DEPTH_WORDS.
- Error handling: skip ACCESS and respond at T+1 with o_RspError=1 and o_RspReadData=0. No array write.
- Store lane steering, little-endian, lane = addr[1:0]:
  - Byte: writes lane addr[1:0] with data[7:0].
  - Half: writes lanes addr[1] pair with data[15:0].
  - Word: writes all four lanes.
- Load formatting: select lane(s) by addr[1:0]; extend to 32 bits per i_ReqUnsigned. Word ignores i_ReqUnsigned.
- Ordering
  - A load following a store to the same word returns the updated data.
  - No other in-flight requests exist.
- Input changes outside IDLE: i_ReqValid and request fields are ignored outside IDLE; the latched copy is used.
- Reset mid-operation: a pending request is dropped. A store whose commit edge has not occurred is never written.

Decomposition:
- Package mem_pkg:
  - enum mem_size_t {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_ILLEGAL}
  - enum mem_rsp_state_t {IDLE, ACCESS, RESPOND}
  - function computing misalignment
- Sub-module load_store_align (combinational) produces:
  - store byte enables and lane-shifted data
  - load lane select with extension
- data_memory_responder owns the FSM, counter, latches and array.

Test Plan:
1. Hold i_Reset=0 for 2 cycles with i_ReqValid=1 -> o_ReqReady=0, o_RspValid=0; after release -> o_ReqReady=1, no response generated.
2. SW 0x10 data 0xDEADBEEF, then LW 0x10 (WAIT_STATES=1) -> each o_RspValid at accept+2; LW data 0xDEADBEEF, error 0.
3. After 2: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
4. SB 0x11 data 0x12345655, then LW 0x10 -> 0xDEAD55EF; SH 0x12 data 0x0000CAFE, then LW 0x10 -> 0xCAFE55EF.
5. LW 0x12, SH 0x13, size=11, SW 0x1000 -> each o_RspValid at accept+1, o_RspError=1, data 0; LW 0xFFC unchanged and LW 0x10 still 0xCAFE55EF.
6. Hold i_RspReady=0 for 5 cycles in RESPOND -> o_RspValid and data stable, o_ReqReady=0, new i_ReqValid ignored. Separately, assert i_Reset=0 during ACCESS of SW 0x20 -> LW 0x20 afterwards returns the prior value.
